max_unpool: RTL

MAX_UNPOOL -- requirements
Module: max_unpool

---
 rtl/max_unpool_pkg.sv | 13 +
 rtl/max_unpool_if.sv | 24 ++
 rtl/max_unpool_buf.sv | 25 ++
 rtl/max_unpool.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/max_unpool_pkg.sv
// Shared types and constants for the max-unpool block.
package max_unpool_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_e;

  localparam int DATA_W  = 16;
  localparam int HIS_W   = 2;
  localparam int ENTRY_W = DATA_W + HIS_W;

  localparam logic [HIS_W-1:0] HIS_TL = 2'd0;
  localparam logic [HIS_W-1:0] HIS_TR = 2'd1;
  localparam logic [HIS_W-1:0] HIS_BL = 2'd2;
  localparam logic [HIS_W-1:0] HIS_BR = 2'd3;
endpackage

// File: rtl/max_unpool_if.sv
// Pooled-input and unpooled-output handshake bundle of max_unpool.
interface max_unpool_if;
  import max_unpool_pkg::*;

  logic              load;
  logic [DATA_W-1:0] in;
  logic [HIS_W-1:0]  history;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic [15:0]       addr;
  logic              out_valid;
  logic              out_ready;
  logic              done_up;

  modport master (
    output load, in, history, out_ready,
    input  in_ready, result, addr, out_valid, done_up
  );

  modport slave (
    input  load, in, history, out_ready,
    output in_ready, result, addr, out_valid, done_up
  );
endinterface

// File: rtl/max_unpool_buf.sv
// Pooled value+history store: one synchronous write port, one asynchronous
// read port with write-through so a word written this cycle is readable at once.
module max_unpool_buf
  import max_unpool_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int IW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [IW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem_q[raddr];

endmodule

// File: rtl/max_unpool.sv
// Max-unpool: collects a SIZE x SIZE pooled map, then streams the 2*SIZE square
// map in raster order. Define MAX_UNPOOL_AVG_EN to spread in>>2 over each 2x2 block.
module max_unpool
  import max_unpool_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  max_unpool_if.slave  bus
);

  localparam int OUT_SIZE = 2 * SIZE;
  localparam int N_IN     = SIZE * SIZE;
  localparam int N_OUT    = OUT_SIZE * OUT_SIZE;
  localparam int CNT_W    = ($clog2(N_OUT + 1) > 6) ? $clog2(N_OUT + 1) : 6;
  localparam int IW       = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [CNT_W-1:0] SIZE_C  = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] LAST_RC = CNT_W'(OUT_SIZE - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    k_q;
  logic [CNT_W-1:0]    r_q, c_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                done_up_q;
  logic [DATA_W-1:0]   result_q;
  logic [15:0]         addr_q;

  logic [CNT_W-1:0]    nr_d, nc_d;
  logic [IW-1:0]       rd_idx_d;
  logic [ENTRY_W-1:0]  rd_entry;
  logic                accept, xfer;

  function automatic logic [DATA_W-1:0] unpool_word(input logic [ENTRY_W-1:0] entry,
                                                     input logic [HIS_W-1:0]   pos);
`ifdef MAX_UNPOOL_AVG_EN
    unpool_word = entry[DATA_W-1:0] >> 2;
`else
    unpool_word = (entry[ENTRY_W-1:DATA_W] == pos) ? entry[DATA_W-1:0] : '0;
`endif
  endfunction

  assign accept = bus.load & in_ready_q;
  assign xfer   = out_valid_q & bus.out_ready;

  // Position of the word to present next: (0,0) while loading, else the raster successor.
  always_comb begin
    nr_d = '0;
    nc_d = '0;
    if (state_q == EMIT) begin
      nr_d = r_q;
      nc_d = c_q + 1'b1;
      if (c_q == LAST_RC) begin
        nc_d = '0;
        nr_d = r_q + 1'b1;
      end
    end
    rd_idx_d = IW'((nr_d >> 1) * SIZE_C + (nc_d >> 1));
  end

  max_unpool_buf #(
    .DEPTH (N_IN),
    .IW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (IW'(k_q)),
    .wdata ({bus.history, bus.in}),
    .raddr (rd_idx_d),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_up_q   <= 1'b0;
      result_q    <= '0;
      addr_q      <= '0;
    end else begin
      done_up_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (k_q == LAST_K) begin
              state_q     <= EMIT;
              k_q         <= '0;
              r_q         <= '0;
              c_q         <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              result_q    <= unpool_word(rd_entry, HIS_TL);
              addr_q      <= '0;
            end else begin
              state_q <= LOAD;
              k_q     <= k_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            if ((r_q == LAST_RC) && (c_q == LAST_RC)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              result_q    <= '0;
              addr_q      <= '0;
              done_up_q   <= 1'b1;
            end else begin
              r_q      <= nr_d;
              c_q      <= nc_d;
              addr_q   <= addr_q + 16'd1;
              result_q <= unpool_word(rd_entry, {nr_d[0], nc_d[0]});
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          r_q        <= '0;
          c_q        <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done_up   = done_up_q;
  assign bus.result    = result_q;
  assign bus.addr      = addr_q;

endmodule
